// File: rtl/pll_reset_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_reset_pkg;

  // Sequencer states, in the order a clean power-up walks through them.
  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABILIZE,
    HOLD,
    RUN
  } state_e;

  // Saturation value of the 8-bit event counters.
  localparam logic [7:0] COUNT_MAX = 8'hFF;

  // Width of a counter that must reach max_cycles-1; never narrower than 1 bit.
  function automatic int cnt_width(input int max_cycles);
    return (max_cycles > 1) ? $clog2(max_cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous control bit.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the chain; clear on reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Power-up sequencer: pulses the PLL reset, waits for a stable lock,
// holds the system reset a little longer, then releases downstream logic.
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int PLL_RESET_CYCLES    = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int SYNC_STAGES         = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  output logic       pll_reset,
  output logic       system_reset,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic [7:0] timeout_count
);

  localparam int MAX_AB = (PLL_RESET_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                          PLL_RESET_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CD = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                          LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW = cnt_width(MAX_CYCLES);

  typedef logic [CW-1:0] cnt_t;

  // Terminal counts: each phase ends on the cycle the counter reaches N-1.
  localparam cnt_t PLL_LAST     = cnt_t'(PLL_RESET_CYCLES - 1);
  localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
  localparam cnt_t STABLE_LAST  = cnt_t'(LOCK_STABLE_CYCLES - 1);
  localparam cnt_t HOLD_LAST    = cnt_t'(RESET_HOLD_CYCLES - 1);

  state_e state;
  state_e state_nxt;
  cnt_t   cnt;
  cnt_t   cnt_nxt;
  logic   lock_sync;
  logic   relock_inc;
  logic   timeout_inc;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (locked),
    .q     (lock_sync)
  );

  // Next-state and shared-counter decode; the counter restarts at every transition.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt   = state;
    cnt_nxt     = cnt + cnt_t'(1);
    relock_inc  = 1'b0;
    timeout_inc = 1'b0;
    unique case (state)
      PLL_RESET: begin
        if (cnt == PLL_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_sync) begin
          state_nxt = STABILIZE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt   = PLL_RESET;
          cnt_nxt     = '0;
          timeout_inc = 1'b1;
        end
      end
      STABILIZE: begin
        if (!lock_sync) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (!lock_sync) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        // Counter parked at zero while running so it cannot wrap.
        cnt_nxt = '0;
        if (!lock_sync) begin
          state_nxt  = PLL_RESET;
          relock_inc = 1'b1;
        end
      end
      default: begin
        state_nxt = PLL_RESET;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and saturating event counters; reset restarts the full sequence.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= PLL_RESET;
      cnt           <= '0;
      relock_count  <= '0;
      timeout_count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (relock_inc && (relock_count != COUNT_MAX)) begin
        relock_count <= relock_count + 8'd1;
      end
      if (timeout_inc && (timeout_count != COUNT_MAX)) begin
        timeout_count <= timeout_count + 8'd1;
      end
    end
  end

  // Moore outputs straight from the state register.
  assign pll_reset    = (state == PLL_RESET);
  assign system_reset = (state != RUN);
  assign ready        = (state == RUN);

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short cycle parameters.
module tb_pll_reset_sequencer;
  import pll_reset_pkg::*;

  localparam int BOUND = 200;

  logic       clock = 1'b0;
  logic       reset;
  logic       locked;
  logic       pll_reset;
  logic       system_reset;
  logic       ready;
  logic [7:0] relock_count;
  logic [7:0] timeout_count;

  int checks = 0;
  int errors = 0;
  int n;

  pll_reset_sequencer #(
    .PLL_RESET_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .RESET_HOLD_CYCLES   (4),
    .SYNC_STAGES         (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .locked        (locked),
    .pll_reset     (pll_reset),
    .system_reset  (system_reset),
    .ready         (ready),
    .relock_count  (relock_count),
    .timeout_count (timeout_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Number of consecutive negedge samples (current one included) with pll_reset high.
  task automatic measure_pll_high(output int cnt);
    cnt = 0;
    while (pll_reset === 1'b1 && cnt < BOUND) begin
      cnt++;
      @(negedge clock);
    end
  endtask

  // Clock edges until ready is seen high; -1 if the bound expires.
  task automatic count_until_ready(output int cnt);
    cnt = 0;
    while (ready !== 1'b1 && cnt < BOUND) begin
      @(negedge clock);
      cnt++;
    end
    if (ready !== 1'b1) cnt = -1;
  endtask

  // Clock edges until system_reset is seen high; -1 if the bound expires.
  task automatic count_until_sysrst(output int cnt);
    cnt = 0;
    while (system_reset !== 1'b1 && cnt < BOUND) begin
      @(negedge clock);
      cnt++;
    end
    if (system_reset !== 1'b1) cnt = -1;
  endtask

  // Clock edges until pll_reset is seen high; -1 if the bound expires.
  task automatic count_until_pll(output int cnt);
    cnt = 0;
    while (pll_reset !== 1'b1 && cnt < BOUND) begin
      @(negedge clock);
      cnt++;
    end
    if (pll_reset !== 1'b1) cnt = -1;
  endtask

  initial begin
    reset  = 1'b1;
    locked = 1'b0;
    repeat (3) @(negedge clock);

    // Reset state.
    check("rst pll_reset", 32'(pll_reset), 1);
    check("rst system_reset", 32'(system_reset), 1);
    check("rst ready", 32'(ready), 0);
    check("rst relock_count", 32'(relock_count), 0);
    check("rst timeout_count", 32'(timeout_count), 0);

    // Clean power-up: 4-cycle pulse, lock 10 cycles after release, ready 15 later.
    reset = 1'b0;
    measure_pll_high(n);
    check("powerup pll pulse", n, 4);
    repeat (6) @(negedge clock);
    locked = 1'b1;
    count_until_ready(n);
    check("powerup lock->ready", n, 15);
    check("powerup system_reset", 32'(system_reset), 0);
    check("powerup pll_reset", 32'(pll_reset), 0);
    check("powerup relock_count", 32'(relock_count), 0);
    check("powerup timeout_count", 32'(timeout_count), 0);

    // Lock loss in RUN.
    locked = 1'b0;
    count_until_sysrst(n);
    check("loss latency", n, 3);
    check("loss ready", 32'(ready), 0);
    check("loss relock_count", 32'(relock_count), 1);
    measure_pll_high(n);
    check("loss pll pulse", n, 4);

    // Lock never arrives: timeouts every 36 cycles.
    for (int k = 1; k <= 3; k++) begin
      count_until_pll(n);
      check("timeout wait", n, 32);
      check("timeout count", 32'(timeout_count), k);
      check("timeout system_reset", 32'(system_reset), 1);
      measure_pll_high(n);
      check("timeout pll pulse", n, 4);
    end

    // Reset pulsed during HOLD.
    locked = 1'b1;
    repeat (12) @(negedge clock);
    check("hold state", 32'(dut.state), 32'(HOLD));
    reset  = 1'b1;
    locked = 1'b0;
    @(negedge clock);
    check("hold-rst state", 32'(dut.state), 32'(PLL_RESET));
    check("hold-rst pll_reset", 32'(pll_reset), 1);
    check("hold-rst ready", 32'(ready), 0);
    check("hold-rst relock_count", 32'(relock_count), 0);
    check("hold-rst timeout_count", 32'(timeout_count), 0);
    reset = 1'b0;
    measure_pll_high(n);
    check("hold-rst pll pulse", n, 4);

    // Lock glitch during STABILIZE, then re-lock.
    locked = 1'b1;
    repeat (5) @(negedge clock);
    check("glitch stabilize", 32'(dut.state), 32'(STABILIZE));
    locked = 1'b0;
    repeat (3) @(negedge clock);
    check("glitch back to wait", 32'(dut.state), 32'(WAIT_LOCK));
    locked = 1'b1;
    count_until_ready(n);
    check("glitch relock->ready", n, 15);
    check("glitch relock_count", 32'(relock_count), 0);

    // Many lock losses: relock_count saturates at 255.
    for (int i = 1; i <= 260; i++) begin
      locked = 1'b0;
      count_until_sysrst(n);
      locked = 1'b1;
      count_until_ready(n);
      if (n < 0) check("sat reached ready", n, 0);
      if (i == 254) check("sat relock 254", 32'(relock_count), 254);
      if (i == 255) check("sat relock 255", 32'(relock_count), 255);
      if (i == 260) check("sat relock held", 32'(relock_count), 255);
    end
    check("sat timeout_count", 32'(timeout_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter PLL_RESET_CYCLES, default 8: cycles pll_reset is held per pulse (>=1).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: cycles WAIT_LOCK waits before re-pulsing the PLL reset (>=1).
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required (>=1).
REQ-004 SHALL have parameter RESET_HOLD_CYCLES, default 16: cycles system_reset stays high after lock is stable (>=1).
REQ-005 SHALL have parameter SYNC_STAGES, default 2: flops in the locked synchronizer (>=2).
REQ-006 SHALL have port clock, input, 1 bit: the single clock, the free-running reference clock and not the PLL output.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port locked, input, 1 bit: PLL lock, asynchronous to clock.
REQ-009 SHALL have port pll_reset, output, 1 bit: drives the PLL RST input.
REQ-010 SHALL have port system_reset, output, 1 bit: active-high reset request to downstream logic.
REQ-011 SHALL have port ready, output, 1 bit: high only while the PLL is locked and sequencing is complete.
REQ-012 SHALL have port relock_count, output, 8 bits: saturating count of lock losses seen in RUN.
REQ-013 SHALL have port timeout_count, output, 8 bits: saturating count of lock timeouts.

Function
REQ-014 SHALL pass locked through SYNC_STAGES flops to lock_sync; only lock_sync is used by the FSM.
REQ-015 SHALL implement the FSM states PLL_RESET, WAIT_LOCK, STABILIZE, HOLD and RUN, with one shared down/up counter sized with $clog2 of the largest cycle parameter.
REQ-016 SHALL decode all outputs from the current state register (Moore): pll_reset=(state==PLL_RESET), system_reset=(state!=RUN), ready=(state==RUN).
REQ-017 SHALL stay in PLL_RESET for exactly PLL_RESET_CYCLES cycles, then enter WAIT_LOCK with the counter cleared.
REQ-018 In WAIT_LOCK, SHALL go to STABILIZE (counter cleared) on the first cycle lock_sync=1, and otherwise after LOCK_TIMEOUT_CYCLES cycles go to PLL_RESET and increment timeout_count.
REQ-019 SHALL stay in STABILIZE for LOCK_STABLE_CYCLES cycles with lock_sync=1, then enter HOLD; lock_sync=0 on any STABILIZE cycle SHALL return it to WAIT_LOCK with the counter cleared and no counter increment.
REQ-020 SHALL stay in HOLD for RESET_HOLD_CYCLES cycles, then enter RUN; lock_sync=0 in HOLD SHALL return it to WAIT_LOCK with the counter cleared.
REQ-021 In RUN, lock_sync=0 SHALL take it to PLL_RESET on the next edge and increment relock_count.
REQ-022 relock_count and timeout_count SHALL saturate at 255 and never wrap.
REQ-023 The lock-loss detection latency in RUN SHALL be at most SYNC_STAGES+1 cycles from the locked fall to system_reset=1.
REQ-024 The locked rise to ready latency from WAIT_LOCK SHALL be exactly SYNC_STAGES+1+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES cycles.

Reset
REQ-025 While reset=1, on each edge SHALL set state=PLL_RESET, counter=0, synchronizer flops=0, relock_count=0 and timeout_count=0; consequently pll_reset=1, system_reset=1, ready=0.
REQ-026 reset asserted in any state, including mid-count, SHALL abort the sequence; after deassertion a full PLL_RESET_CYCLES pulse SHALL follow.

Structure
REQ-027 The package pll_reset_pkg SHALL hold the state enum typedef and the counter-width helper.
REQ-028 The synchronizer SHALL be the sub-module sync_ff (parameter STAGES, 1-bit data); the FSM and counters SHALL live in pll_reset_sequencer.

Verification (PLL_RESET_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, RESET_HOLD=4, SYNC_STAGES=2)
REQ-029 SHALL cover: reset released, locked rises 10 cycles later and stays high -> pll_reset high exactly 4 cycles, ready rises exactly 15 cycles after the locked rise, counts 0.
REQ-030 SHALL cover: locked held 0 -> pll_reset pulses of 4 cycles repeat every 36 cycles, timeout_count increments 1,2,3..., system_reset stays 1.
REQ-031 SHALL cover: locked drops for 3 cycles during STABILIZE -> back to WAIT_LOCK, ready rises 15 cycles after the re-rise, relock_count stays 0.
REQ-032 SHALL cover: locked falls in RUN -> system_reset=1 and ready=0 within 3 cycles, relock_count=1, a 4-cycle pll_reset pulse follows.
REQ-033 SHALL cover: reset pulsed during HOLD -> next cycle state=PLL_RESET, both counts 0, full sequence repeats.
REQ-034 SHALL cover: 260 lock losses in RUN -> relock_count reads 255 and holds.
